// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the fetch front end: RISC-V opcodes used for next-PC prediction,
// the instruction-queue entry layout, the fetch FSM state type and immediate decoders.
// The opcode constants and entry width are also used by the decoder.
package inst_fetcher_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        jump;
    } iq_entry_t;

    localparam int unsigned IQ_ENTRY_W = $bits(iq_entry_t);

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StDrop
    } fetch_state_e;

    // J-type immediate, sign-extended.
    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // B-type immediate, sign-extended.
    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/inst_fetcher_iq.sv
// In-order instruction queue: circular FIFO of packed fetch entries.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data write one entry at the tail (caller guarantees !full or same-cycle pop)
//   pop             drop the head entry (caller guarantees !empty)
//   flush           synchronous clear of pointers and count; wins over push/pop
//   head_data       entry at the head (meaningless while empty)
//   empty, full     occupancy flags
module inst_fetcher_iq
    import inst_fetcher_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [IQ_ENTRY_W-1:0] push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [IQ_ENTRY_W-1:0] head_data,
    output logic                  empty,
    output logic                  full
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [IQ_ENTRY_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       count_q;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CntW'(DEPTH));
    assign head_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Data storage needs no reset; the head is only observed while the queue is non-empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/inst_fetcher.sv
// Fetch stage: PC generation, single-outstanding icache request FSM, next-PC prediction and
// an in-order instruction queue whose head feeds the dispatcher through if_*.
// Optional feature macro: FETCH_BHT_EN adds a table of 2-bit saturating counters for
// conditional-branch prediction; without it branches are predicted not-taken.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rdy                        global enable; all state frozen while low
//   wrong_commit, redirect_pc  mispredict flush and corrected PC
//   ic_req_valid, ic_req_pc    icache request (held until response)
//   ic_resp_valid, ic_resp_inst icache response
//   issue_stall                dispatcher back-pressure
//   if_valid/if_inst/if_pc/if_jump  queue head toward the dispatcher
//   bht_upd_valid/pc/taken     resolved-branch training (FETCH_BHT_EN only)
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int unsigned IQ_DEPTH  = 8,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int unsigned BHT_IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        wrong_commit,
    input  logic [31:0] redirect_pc,
    output logic        ic_req_valid,
    output logic [31:0] ic_req_pc,
    input  logic        ic_resp_valid,
    input  logic [31:0] ic_resp_inst,
    input  logic        issue_stall,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_jump,
    input  logic        bht_upd_valid,
    input  logic [31:0] bht_upd_pc,
    input  logic        bht_upd_taken
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         req_valid_q, req_valid_d;
    logic [31:0]  req_pc_q, req_pc_d;

    logic                  iq_push, iq_pop, iq_flush;
    logic                  iq_empty, iq_full;
    logic [IQ_ENTRY_W-1:0] iq_head_data;
    iq_entry_t             iq_head, iq_new;

    logic        pred_taken;
    logic [31:0] resp_next_pc;
    logic        resp_jump;

    // ---------------- branch prediction ----------------
`ifdef FETCH_BHT_EN
    localparam int unsigned BhtEntries = 1 << BHT_IDX_W;

    logic [1:0]           bht_q [BhtEntries];
    logic [BHT_IDX_W-1:0] lookup_idx, upd_idx;
    logic                 unused_upd_pc_bits;

    assign lookup_idx = req_pc_q[BHT_IDX_W+1:2];
    assign upd_idx    = bht_upd_pc[BHT_IDX_W+1:2];
    assign pred_taken = bht_q[lookup_idx][1];
    assign unused_upd_pc_bits = ^{bht_upd_pc[31:BHT_IDX_W+2], bht_upd_pc[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BhtEntries; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (rdy && bht_upd_valid) begin
            if (bht_upd_taken && bht_q[upd_idx] != 2'b11) begin
                bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
            end else if (!bht_upd_taken && bht_q[upd_idx] != 2'b00) begin
                bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
            end
        end
    end
`else
    logic                 unused_bht;
    logic [BHT_IDX_W-1:0] unused_bht_idx;

    assign pred_taken     = 1'b0;
    assign unused_bht     = ^{bht_upd_valid, bht_upd_pc, bht_upd_taken};
    assign unused_bht_idx = '0;
`endif

    // ---------------- next-PC for the returning instruction ----------------
    // req_pc_q is the address of the instruction carried by the current response.
    always_comb begin
        resp_next_pc = req_pc_q + 32'd4;
        resp_jump    = 1'b0;
        case (ic_resp_inst[6:0])
            OP_JAL: begin
                resp_next_pc = req_pc_q + imm_j(ic_resp_inst);
                resp_jump    = 1'b1;
            end
            OP_BRANCH: begin
                if (pred_taken) begin
                    resp_next_pc = req_pc_q + imm_b(ic_resp_inst);
                    resp_jump    = 1'b1;
                end
            end
            // Register-indirect target is unknown here; fall through sequentially.
            OP_JALR: ;
            default: ;
        endcase
    end

    assign iq_new = '{inst: ic_resp_inst, pc: req_pc_q, jump: resp_jump};

    // ---------------- fetch FSM ----------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_valid_d = req_valid_q;
        req_pc_d    = req_pc_q;
        iq_push     = 1'b0;
        iq_pop      = 1'b0;
        iq_flush    = 1'b0;

        if (rdy) begin
            if (wrong_commit) begin
                iq_flush = 1'b1;
                pc_d     = redirect_pc;
                // A request still in flight must have its response swallowed.
                if (state_q != StFetch && !ic_resp_valid) begin
                    state_d = StDrop;
                end else begin
                    state_d     = StFetch;
                    req_valid_d = 1'b0;
                end
            end else begin
                iq_pop = !iq_empty && !issue_stall;
                unique case (state_q)
                    StFetch: begin
                        // Nothing is outstanding here, so a free slot guarantees the
                        // response will fit even with no pop.
                        if (!iq_full) begin
                            req_valid_d = 1'b1;
                            req_pc_d    = pc_q;
                            state_d     = StWait;
                        end
                    end
                    StWait: begin
                        if (ic_resp_valid) begin
                            iq_push     = 1'b1;
                            pc_d        = resp_next_pc;
                            req_valid_d = 1'b0;
                            state_d     = StFetch;
                        end
                    end
                    StDrop: begin
                        if (ic_resp_valid) begin
                            req_valid_d = 1'b0;
                            state_d     = StFetch;
                        end
                    end
                    default: state_d = StFetch;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            req_pc_q    <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_valid_q <= req_valid_d;
            req_pc_q    <= req_pc_d;
        end
    end

    assign ic_req_valid = req_valid_q;
    assign ic_req_pc    = req_pc_q;

    // ---------------- instruction queue ----------------
    inst_fetcher_iq #(
        .DEPTH (IQ_DEPTH)
    ) u_iq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (iq_push),
        .push_data (iq_new),
        .pop       (iq_pop),
        .flush     (iq_flush),
        .head_data (iq_head_data),
        .empty     (iq_empty),
        .full      (iq_full)
    );

    assign iq_head  = iq_entry_t'(iq_head_data);
    assign if_valid = !iq_empty;
    assign if_inst  = iq_empty ? 32'h0 : iq_head.inst;
    assign if_pc    = iq_empty ? 32'h0 : iq_head.pc;
    assign if_jump  = iq_empty ? 1'b0  : iq_head.jump;

endmodule
